// File: rtl/fiber_mem_port_arbiter.sv
// rtl/fiber_mem_port_arbiter.sv - single-port SRAM arbiter with read response FIFO
//
// fiber_mem_port_arbiter_rsp_fifo: read-response queue
//   clk, flush          clock, synchronous active-high reset
//   push, push_data     enqueue one SRAM word
//   pop                 dequeue head (ignored when empty)
//   head_data           head word, zero when empty
//   head_valid          queue non-empty
//   occ                 current entry count
//
// fiber_mem_port_arbiter: shares one sram_sp between a write and a read requester
//   clk, flush, clk_en, tile_en                   clocking, reset, enables
//   wr_req_addr/data/valid, wr_req_ready          write request channel
//   rd_req_addr/valid, rd_req_ready               read request channel
//   rd_rsp_data/valid, rd_rsp_ready               read response channel
//   addr_to_mem, data_to_mem, wen_to_mem,
//   ren_to_mem, data_from_mem                     SRAM port

module fiber_mem_port_arbiter_rsp_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [OCC_W-1:0]  occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ_q;
    logic              do_push;
    logic              do_pop;
    logic              full;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full       = (occ_q == OCC_W'(DEPTH));
    assign head_valid = (occ_q != '0);
    assign do_pop     = pop & head_valid;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push    = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = head_valid ? mem[rd_ptr] : '0;
    assign occ       = occ_q;

endmodule

module fiber_mem_port_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 64,
    parameter int RESP_DEPTH  = 2,
    parameter int WR_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              clk_en,
    input  logic              tile_en,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic [DATA_W-1:0] data_to_mem,
    output logic              wen_to_mem,
    output logic              ren_to_mem,
    input  logic [DATA_W-1:0] data_from_mem
);

    localparam int   OCC_W   = $clog2(RESP_DEPTH + 1);
    localparam int   SLOT_W  = OCC_W + 1;
    localparam logic WR_PRIO = (WR_PRIORITY != 0);

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    grant_t            last_grant;
    grant_t            last_grant_nxt;
    logic              inflight;
    logic              active;
    logic              pop;
    logic              rd_slot;
    logic              wr_elig;
    logic              rd_elig;
    logic              wr_gnt;
    logic              rd_gnt;
    logic [OCC_W-1:0]  occ;
    logic [SLOT_W-1:0] slot_use;

    assign active = tile_en & clk_en & ~flush;
    assign pop    = rd_rsp_valid & rd_rsp_ready;

    // Slots already spoken for: queued words plus the read in flight, minus the
    // head leaving this cycle. pop implies occ >= 1, so this never underflows.
    assign slot_use = SLOT_W'(occ) + SLOT_W'(inflight) - SLOT_W'(pop);
    assign rd_slot  = (slot_use < SLOT_W'(RESP_DEPTH));

    assign wr_elig = active & wr_req_valid;
    assign rd_elig = active & rd_req_valid & rd_slot;

    always_comb begin
        wr_gnt         = 1'b0;
        rd_gnt         = 1'b0;
        last_grant_nxt = last_grant;
        if (wr_elig && rd_elig) begin
            if (WR_PRIO || (last_grant == GRANT_RD)) begin
                wr_gnt = 1'b1;
            end else begin
                rd_gnt = 1'b1;
            end
        end else if (wr_elig) begin
            wr_gnt = 1'b1;
        end else if (rd_elig) begin
            rd_gnt = 1'b1;
        end
        if (wr_gnt) begin
            last_grant_nxt = GRANT_WR;
        end else if (rd_gnt) begin
            last_grant_nxt = GRANT_RD;
        end
    end

    // inflight only advances with clk_en, so a read whose data is due during a
    // frozen cycle is captured on the next enabled cycle (the SRAM holds its output).
    always_ff @(posedge clk) begin
        if (flush) begin
            last_grant <= GRANT_RD;
            inflight   <= 1'b0;
        end else if (clk_en) begin
            last_grant <= last_grant_nxt;
            inflight   <= rd_gnt;
        end
    end

    fiber_mem_port_arbiter_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH),
        .OCC_W  (OCC_W)
    ) u_rsp_fifo (
        .clk        (clk),
        .flush      (flush),
        .push       (inflight & clk_en),
        .push_data  (data_from_mem),
        .pop        (pop & clk_en),
        .head_data  (rd_rsp_data),
        .head_valid (rd_rsp_valid),
        .occ        (occ)
    );

    assign wr_req_ready = wr_gnt;
    assign rd_req_ready = rd_gnt;
    assign wen_to_mem   = wr_gnt;
    assign ren_to_mem   = rd_gnt;
    assign addr_to_mem  = wr_gnt ? wr_req_addr : rd_req_addr;
    assign data_to_mem  = wr_req_data;

endmodule

// File: tb/tb_fiber_mem_port_arbiter.sv
// tb/tb_fiber_mem_port_arbiter.sv - directed bench for fiber_mem_port_arbiter

module tb_fiber_mem_port_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              flush = 1'b1;
    logic              clk_en = 1'b1;
    logic              tile_en = 1'b1;
    logic [ADDR_W-1:0] wr_req_addr = '0;
    logic [DATA_W-1:0] wr_req_data = '0;
    logic              wr_req_valid = 1'b0;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] rd_req_addr = '0;
    logic              rd_req_valid = 1'b0;
    logic              rd_req_ready;
    logic [DATA_W-1:0] rd_rsp_data;
    logic              rd_rsp_valid;
    logic              rd_rsp_ready = 1'b0;
    logic [ADDR_W-1:0] addr_to_mem;
    logic [DATA_W-1:0] data_to_mem;
    logic              wen_to_mem;
    logic              ren_to_mem;
    logic [DATA_W-1:0] data_from_mem = '0;

    logic [DATA_W-1:0] sram [512];
    logic [63:0]       exp_q [$];
    logic              mon_en = 1'b0;
    int                n_checks = 0;
    int                n_errors = 0;
    int                k;

    fiber_mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RESP_DEPTH  (2),
        .WR_PRIORITY (0)
    ) dut (
        .clk           (clk),
        .flush         (flush),
        .clk_en        (clk_en),
        .tile_en       (tile_en),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_rsp_data   (rd_rsp_data),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_ready  (rd_rsp_ready),
        .addr_to_mem   (addr_to_mem),
        .data_to_mem   (data_to_mem),
        .wen_to_mem    (wen_to_mem),
        .ren_to_mem    (ren_to_mem),
        .data_from_mem (data_from_mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
        if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("wen_ren_excl", 64'(wen_to_mem & ren_to_mem), 64'd0);
            if (rd_rsp_valid && rd_rsp_ready && clk_en && !flush) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("rsp_data", rd_rsp_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        flush = 1'b0;
        settle();
        check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
        check("rst_rsp_data", rd_rsp_data, 64'd0);
        check("rst_wen", 64'(wen_to_mem), 64'd0);
        check("rst_ren", 64'(ren_to_mem), 64'd0);
        check("rst_wrdy", 64'(wr_req_ready), 64'd0);
        check("rst_rrdy", 64'(rd_req_ready), 64'd0);
        mon_en = 1'b1;

        tile_en = 1'b0;
        wr_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        settle();
        check("tile_off_wen", 64'(wen_to_mem), 64'd0);
        check("tile_off_ren", 64'(ren_to_mem), 64'd0);
        tick();
        tile_en = 1'b1;
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;

        // 1: four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            wr_req_valid = 1'b1;
            wr_req_addr  = 9'(i);
            wr_req_data  = 64'hA0 + 64'(i);
            settle();
            check("t1_wen", 64'(wen_to_mem), 64'd1);
            check("t1_ren", 64'(ren_to_mem), 64'd0);
            check("t1_wrdy", 64'(wr_req_ready), 64'd1);
            check("t1_addr", 64'(addr_to_mem), 64'(i));
            check("t1_data", data_to_mem, 64'hA0 + 64'(i));
            tick();
        end
        wr_req_valid = 1'b0;
        settle();
        check("t1_idle_wen", 64'(wen_to_mem), 64'd0);

        // 2: read after write, two-cycle latency
        exp_q.push_back(64'hA2);
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_addr  = 9'd2;
        settle();
        check("t2_ren", 64'(ren_to_mem), 64'd1);
        check("t2_rrdy", 64'(rd_req_ready), 64'd1);
        check("t2_addr", 64'(addr_to_mem), 64'd2);
        tick();
        rd_req_valid = 1'b0;
        settle();
        check("t2_n1_valid", 64'(rd_rsp_valid), 64'd0);
        tick();
        settle();
        check("t2_n2_valid", 64'(rd_rsp_valid), 64'd1);
        check("t2_n2_data", rd_rsp_data, 64'hA2);
        tick();
        settle();
        check("t2_n3_valid", 64'(rd_rsp_valid), 64'd0);

        // 3: contention alternates W,R,W,R,W,R after a flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(64'hA3);
        for (int i = 0; i < 6; i++) begin
            wr_req_valid = 1'b1;
            wr_req_addr  = 9'(10 + (i + 1) / 2);
            wr_req_data  = 64'hB0 + 64'((i + 1) / 2);
            rd_req_valid = 1'b1;
            rd_req_addr  = 9'd3;
            settle();
            check("t3_wen", 64'(wen_to_mem), 64'((i % 2) == 0));
            check("t3_ren", 64'(ren_to_mem), 64'((i % 2) == 1));
            tick();
        end
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        repeat (4) tick();
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // 4: backpressure, only two reads fit until the consumer drains
        exp_q.push_back(64'hA0);
        exp_q.push_back(64'hA1);
        exp_q.push_back(64'hA2);
        exp_q.push_back(64'hA3);
        exp_q.push_back(64'hB0);
        rd_rsp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = (k == 4) ? 9'd10 : 9'(k);
            settle();
            check("t4_rrdy", 64'(rd_req_ready), 64'(c < 2));
            if (rd_req_ready) k++;
            tick();
        end
        settle();
        check("t4_full_valid", 64'(rd_rsp_valid), 64'd1);
        check("t4_full_granted", 64'(k), 64'd2);
        rd_rsp_ready = 1'b1;
        for (int c = 0; c < 20 && k < 5; c++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = (k == 4) ? 9'd10 : 9'(k);
            settle();
            if (rd_req_ready) k++;
            tick();
        end
        rd_req_valid = 1'b0;
        repeat (4) tick();
        check("t4_granted", 64'(k), 64'd5);
        check("t4_drained", 64'(exp_q.size()), 64'd0);

        // 5: flush with one read in flight and one queued
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 9'd0;
        settle();
        check("t5_ren0", 64'(ren_to_mem), 64'd1);
        tick();
        rd_req_addr = 9'd1;
        settle();
        check("t5_ren1", 64'(ren_to_mem), 64'd1);
        tick();
        rd_req_valid = 1'b0;
        flush        = 1'b1;
        wr_req_valid = 1'b1;
        wr_req_addr  = 9'd5;
        wr_req_data  = 64'hFF;
        settle();
        check("t5_pre_valid", 64'(rd_rsp_valid), 64'd1);
        check("t5_flush_wen", 64'(wen_to_mem), 64'd0);
        check("t5_flush_wrdy", 64'(wr_req_ready), 64'd0);
        tick();
        flush        = 1'b0;
        wr_req_valid = 1'b0;
        rd_rsp_ready = 1'b1;
        settle();
        check("t5_post_valid", 64'(rd_rsp_valid), 64'd0);
        repeat (4) begin
            tick();
            settle();
            check("t5_stay_empty", 64'(rd_rsp_valid), 64'd0);
        end

        // 6: streaming reads with clk_en toggling every cycle
        exp_q.push_back(64'hA0);
        exp_q.push_back(64'hA1);
        exp_q.push_back(64'hA2);
        exp_q.push_back(64'hA3);
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            clk_en       = ((c % 2) == 1);
            rd_req_valid = 1'b1;
            rd_req_addr  = 9'(k);
            settle();
            if (!clk_en) check("t6_ren_off", 64'(ren_to_mem), 64'd0);
            if (rd_req_ready) k++;
            tick();
        end
        rd_req_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            clk_en = ((c % 2) == 1);
            tick();
        end
        clk_en = 1'b1;
        settle();
        check("t6_granted", 64'(k), 64'd4);
        check("t6_drained", 64'(exp_q.size()), 64'd0);
        check("t6_end_valid", 64'(rd_rsp_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
